// File: rtl/mux8_rr_collector.sv
// Eight-lane round-robin collector: merges valid lanes onto one registered,
// lane-tagged output stream with a skid-free 1 beat/cycle handshake.
module mux8_rr_collector #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [8*WIDTH-1:0] in_data,
  input  logic [7:0]         in_valid,
  output logic [7:0]         in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        beat_count
);

  logic [WIDTH-1:0] r_data_p1;
  logic [2:0]       r_sel_p1;
  logic             r_vld_p1;
  logic [15:0]      r_cnt;
  logic [2:0]       r_ptr;

  logic [2:0]       w_grant;
  logic             w_load;

  // Search starts at the pointer so the lane after the last winner has priority.
  function automatic logic [2:0] rr_search(input logic [7:0] valid,
                                           input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_search = ptr;
    found     = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = ptr + 3'(k);
      if (!found && valid[idx]) begin
        found     = 1'b1;
        rr_search = idx;
      end
    end
  endfunction

  always_comb begin
    w_grant  = rr_search(in_valid, r_ptr);
    w_load   = rst_n && (!r_vld_p1 || out_ready) && (in_valid != 8'h00);
    in_ready = w_load ? (8'h01 << w_grant) : 8'h00;
  end

  // Stage p1: output register, loaded from the granted lane.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_p1 <= '0;
      r_sel_p1  <= 3'd0;
      r_vld_p1  <= 1'b0;
      r_ptr     <= 3'd0;
      r_cnt     <= 16'h0000;
    end else if (w_load) begin
      r_data_p1 <= in_data[w_grant*WIDTH +: WIDTH];
      r_sel_p1  <= w_grant;
      r_vld_p1  <= 1'b1;
      r_ptr     <= w_grant + 3'd1;
      r_cnt     <= r_cnt + 16'h0001;
    end else if (out_ready) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign out_data   = r_data_p1;
  assign out_sel    = r_sel_p1;
  assign out_valid  = r_vld_p1;
  assign beat_count = r_cnt;

endmodule

// File: tb/tb_mux8_rr_collector.sv
// Bench for mux8_rr_collector: directed vector table, randomized traffic
// against a round-robin reference model, and a beat-counter wrap check.
module tb_mux8_rr_collector;

  localparam int W = 8;

  logic          clk;
  logic          rst_n;
  logic [8*W-1:0] in_data;
  logic [7:0]    in_valid;
  logic [7:0]    in_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_sel;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   beat_count;

  mux8_rr_collector #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_vld;
  logic [7:0] m_data;
  logic [2:0] m_sel;
  int         m_ptr;
  logic [15:0] m_cnt;

  typedef struct {
    logic        rn;
    logic [7:0]  v;
    logic [63:0] d;
    logic        ordy;
    logic [7:0]  e_rdy;
    logic        e_vld;
    logic [2:0]  e_sel;
    logic [7:0]  e_data;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] D_A = 64'hA7A6A5A4A3A2A1A0;
  localparam logic [63:0] D_1 = 64'h1716151413121110;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Winner = valid lane at the smallest forward distance from the pointer.
  function automatic int model_grant(input logic [7:0] v, input int ptr);
    int best, bestd, d;
    best = 0; bestd = 99;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) begin
        d = (i - ptr + 8) % 8;
        if (d < bestd) begin bestd = d; best = i; end
      end
    end
    return best;
  endfunction

  task automatic step(input logic rn, input logic [7:0] v, input logic [63:0] d,
                      input logic ordy, output logic [7:0] rdy_seen);
    logic ld;
    int g;
    logic [7:0] exp_rdy;
    rst_n = rn; in_valid = v; in_data = d; out_ready = ordy;
    #1;
    g = model_grant(v, m_ptr);
    ld = rn && (!m_vld || ordy) && (v != 8'h00);
    exp_rdy = ld ? (8'h01 << g) : 8'h00;
    rdy_seen = in_ready;
    check("in_ready", {56'h0, in_ready}, {56'h0, exp_rdy});
    @(posedge clk);
    if (!rn) begin
      m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    end else if (ld) begin
      m_vld = 1; m_data = d[g*8 +: 8]; m_sel = 3'(g);
      m_ptr = (g + 1) % 8; m_cnt = m_cnt + 16'd1;
    end else if (ordy) begin
      m_vld = 0;
    end
    #1;
    check("out_valid", {63'h0, out_valid}, {63'h0, m_vld});
    check("out_data", {56'h0, out_data}, {56'h0, m_data});
    check("out_sel", {61'h0, out_sel}, {61'h0, m_sel});
    check("beat_count", {48'h0, beat_count}, {48'h0, m_cnt});
  endtask

  function automatic vec_t mk(input logic rn, input logic [7:0] v, input logic [63:0] d,
                              input logic ordy, input logic [7:0] e_rdy, input logic e_vld,
                              input logic [2:0] e_sel, input logic [7:0] e_data,
                              input logic [15:0] e_cnt);
    vec_t r;
    r.rn = rn; r.v = v; r.d = d; r.ordy = ordy; r.e_rdy = e_rdy;
    r.e_vld = e_vld; r.e_sel = e_sel; r.e_data = e_data; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    logic [7:0] rs;
    logic rn, ordy;
    logic [7:0] v;
    logic [63:0] d;

    m_vld = 0; m_data = 0; m_sel = 0; m_ptr = 0; m_cnt = 0;
    rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0;

    // Reset, lane 7 single beat, then idle drain
    tbl.push_back(mk(0, 8'hFF, D_A, 1, 8'h00, 0, 3'd0, 8'h00, 16'd0));
    tbl.push_back(mk(0, 8'hFF, D_A, 1, 8'h00, 0, 3'd0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 8'h80, D_A, 1, 8'h80, 1, 3'd7, 8'hA7, 16'd1));
    tbl.push_back(mk(1, 8'h00, D_A, 1, 8'h00, 0, 3'd7, 8'hA7, 16'd1));
    // All lanes valid after reset: 0..7 back to back
    tbl.push_back(mk(0, 8'h00, D_1, 1, 8'h00, 0, 3'd0, 8'h00, 16'd0));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 8'hFF, D_1, 1, 8'h01 << k, 1, 3'(k), 8'h10 + 8'(k), 16'(k + 1)));
    // Stall with lane 3 held, lanes 5/6 waiting
    tbl.push_back(mk(1, 8'h08, D_1, 1, 8'h08, 1, 3'd3, 8'h13, 16'd9));
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(1, 8'h60, D_1, 0, 8'h00, 1, 3'd3, 8'h13, 16'd9));
    tbl.push_back(mk(1, 8'h60, D_1, 1, 8'h20, 1, 3'd5, 8'h15, 16'd10));
    tbl.push_back(mk(1, 8'h60, D_1, 1, 8'h40, 1, 3'd6, 8'h16, 16'd11));
    // Lanes 2 and 6 alternate
    tbl.push_back(mk(1, 8'h44, D_1, 1, 8'h04, 1, 3'd2, 8'h12, 16'd12));
    tbl.push_back(mk(1, 8'h44, D_1, 1, 8'h40, 1, 3'd6, 8'h16, 16'd13));
    tbl.push_back(mk(1, 8'h44, D_1, 1, 8'h04, 1, 3'd2, 8'h12, 16'd14));
    tbl.push_back(mk(1, 8'h44, D_1, 1, 8'h40, 1, 3'd6, 8'h16, 16'd15));
    // Reset during stall, then lanes 0 and 3 from pointer 0
    tbl.push_back(mk(1, 8'h00, D_1, 0, 8'h00, 1, 3'd6, 8'h16, 16'd15));
    tbl.push_back(mk(0, 8'hFF, D_1, 0, 8'h00, 0, 3'd0, 8'h00, 16'd0));
    tbl.push_back(mk(1, 8'h09, D_1, 1, 8'h01, 1, 3'd0, 8'h10, 16'd1));
    tbl.push_back(mk(1, 8'h09, D_1, 1, 8'h08, 1, 3'd3, 8'h13, 16'd2));
    tbl.push_back(mk(1, 8'h00, D_1, 1, 8'h00, 0, 3'd3, 8'h13, 16'd2));

    @(posedge clk); #1;

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].v, tbl[i].d, tbl[i].ordy, rs);
      check($sformatf("t%0d_rdy", i), {56'h0, rs}, {56'h0, tbl[i].e_rdy});
      check($sformatf("t%0d_vld", i), {63'h0, out_valid}, {63'h0, tbl[i].e_vld});
      check($sformatf("t%0d_sel", i), {61'h0, out_sel}, {61'h0, tbl[i].e_sel});
      check($sformatf("t%0d_data", i), {56'h0, out_data}, {56'h0, tbl[i].e_data});
      check($sformatf("t%0d_cnt", i), {48'h0, beat_count}, {48'h0, tbl[i].e_cnt});
    end

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rn = ($urandom_range(0, 99) != 0);
      case ($urandom_range(0, 3))
        0: v = 8'($urandom);
        1: v = 8'($urandom) & 8'($urandom) & 8'($urandom);
        2: v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'hFF;
      endcase
      d = {$urandom, $urandom};
      ordy = ($urandom_range(0, 3) != 0);
      step(rn, v, d, ordy, rs);
    end

    // Counter wrap: 65535 loads, then one more
    step(0, 8'h00, D_1, 1, rs);
    rst_n = 1; in_valid = 8'hFF; in_data = D_1; out_ready = 1;
    repeat (65535) @(posedge clk);
    #1;
    check("cnt_ffff", {48'h0, beat_count}, 64'hFFFF);
    @(posedge clk); #1;
    check("cnt_wrap", {48'h0, beat_count}, 64'h0000);
    check("wrap_vld", {63'h0, out_valid}, 64'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
